// File: rtl/reg_file.sv
// Architectural register file with per-register busy/tag rename state for a ROB-based core.
// Optional macro REG_FILE_BYPASS_EN forwards a matching commit straight onto the read ports.
module reg_file #(
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             rollback,
   input  logic             issue,
   input  logic [4:0]       issue_rd,
   input  logic [TAG_W-1:0] issue_rob_pos,
   input  logic             reg_write,
   input  logic [4:0]       reg_rd,
   input  logic [31:0]      reg_val,
   input  logic [TAG_W-1:0] commit_rob_pos,
   input  logic [4:0]       rs1,
   input  logic [4:0]       rs2,
   output logic [31:0]      rs1_val,
   output logic [31:0]      rs2_val,
   output logic             rs1_busy,
   output logic             rs2_busy,
   output logic [TAG_W-1:0] rs1_tag,
   output logic [TAG_W-1:0] rs2_tag
);

   logic [31:0]      val [32];
   logic [31:0]      busy;
   logic [TAG_W-1:0] tag [32];

   logic commit_en;
   logic issue_en;

   assign commit_en = reg_write && (reg_rd != 5'd0);
   assign issue_en  = issue && (issue_rd != 5'd0);

   // Issue is applied after the commit so that a same-register collision keeps the new producer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            val[i] <= '0;
            tag[i] <= '0;
         end
         busy <= '0;
      end else if (rdy) begin
         if (commit_en) begin
            val[reg_rd] <= reg_val;
            if (tag[reg_rd] == commit_rob_pos) begin
               busy[reg_rd] <= 1'b0;
            end
         end
         if (rollback) begin
            busy <= '0;
         end else if (issue_en) begin
            busy[issue_rd] <= 1'b1;
            tag[issue_rd]  <= issue_rob_pos;
         end
      end
   end

`ifdef REG_FILE_BYPASS_EN
   logic hit1;
   logic hit2;

   assign hit1 = commit_en && (rs1 == reg_rd) && busy[rs1] && (tag[rs1] == commit_rob_pos);
   assign hit2 = commit_en && (rs2 == reg_rd) && busy[rs2] && (tag[rs2] == commit_rob_pos);
`endif

   always_comb begin
      rs1_val  = '0;
      rs1_busy = 1'b0;
      rs1_tag  = '0;
      if (rs1 != 5'd0) begin
         rs1_val  = val[rs1];
         rs1_busy = busy[rs1];
         rs1_tag  = tag[rs1];
`ifdef REG_FILE_BYPASS_EN
         if (hit1) begin
            rs1_val  = reg_val;
            rs1_busy = 1'b0;
            rs1_tag  = '0;
         end
`endif
      end
   end

   always_comb begin
      rs2_val  = '0;
      rs2_busy = 1'b0;
      rs2_tag  = '0;
      if (rs2 != 5'd0) begin
         rs2_val  = val[rs2];
         rs2_busy = busy[rs2];
         rs2_tag  = tag[rs2];
`ifdef REG_FILE_BYPASS_EN
         if (hit2) begin
            rs2_val  = reg_val;
            rs2_busy = 1'b0;
            rs2_tag  = '0;
         end
`endif
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against a behavioural model.
module tb_reg_file;
   localparam int TAG_W = 4;

   logic             clk = 1'b0;
   logic             rst, rdy, rollback, issue, reg_write;
   logic [4:0]       issue_rd, reg_rd, rs1, rs2;
   logic [TAG_W-1:0] issue_rob_pos, commit_rob_pos;
   logic [31:0]      reg_val;
   logic [31:0]      rs1_val, rs2_val;
   logic             rs1_busy, rs2_busy;
   logic [TAG_W-1:0] rs1_tag, rs2_tag;

   int total = 0;
   int bad   = 0;
   bit chk_on = 1'b0;

   // reference state: what each architectural register holds and who it waits on
   logic [31:0]      m_val  [32];
   bit               m_busy [32];
   logic [TAG_W-1:0] m_tag  [32];

   reg_file #(.TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
      .issue(issue), .issue_rd(issue_rd), .issue_rob_pos(issue_rob_pos),
      .reg_write(reg_write), .reg_rd(reg_rd), .reg_val(reg_val),
      .commit_rob_pos(commit_rob_pos), .rs1(rs1), .rs2(rs2),
      .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy),
      .rs2_busy(rs2_busy), .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
   );

   always #5 clk = ~clk;

   initial begin
      for (int i = 0; i < 32; i++) begin
         m_val[i] = '0; m_busy[i] = 0; m_tag[i] = '0;
      end
   end

   always @(posedge clk) begin
      logic [31:0]      nv [32];
      bit               nb [32];
      logic [TAG_W-1:0] nt [32];
      nv = m_val; nb = m_busy; nt = m_tag;
      if (!rst) begin
         for (int i = 0; i < 32; i++) begin
            nv[i] = '0; nb[i] = 0; nt[i] = '0;
         end
      end else if (rdy) begin
         if (reg_write && reg_rd != 0) begin
            nv[reg_rd] = reg_val;
            if (m_tag[reg_rd] == commit_rob_pos) nb[reg_rd] = 0;
         end
         if (rollback) begin
            for (int i = 0; i < 32; i++) nb[i] = 0;
         end else if (issue && issue_rd != 0) begin
            nb[issue_rd] = 1;
            nt[issue_rd] = issue_rob_pos;
         end
      end
      m_val = nv; m_busy = nb; m_tag = nt;
   end

   task automatic expect_read(input logic [4:0] idx, output logic [31:0] v,
                              output bit b, output logic [TAG_W-1:0] t);
      v = '0; b = 0; t = '0;
      if (idx != 0) begin
         v = m_val[idx]; b = m_busy[idx]; t = m_tag[idx];
`ifdef REG_FILE_BYPASS_EN
         if (reg_write && idx == reg_rd && m_busy[idx] && m_tag[idx] == commit_rob_pos) begin
            v = reg_val; b = 0; t = '0;
         end
`endif
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // tags are only meaningful while busy, so they are compared only then
   always @(negedge clk) begin
      logic [31:0] v; bit b; logic [TAG_W-1:0] t;
      if (chk_on) begin
         expect_read(rs1, v, b, t);
         check("rs1_val", rs1_val, v);
         check("rs1_busy", {31'd0, rs1_busy}, {31'd0, b});
         if (b) check("rs1_tag", {28'd0, rs1_tag}, {28'd0, t});
         expect_read(rs2, v, b, t);
         check("rs2_val", rs2_val, v);
         check("rs2_busy", {31'd0, rs2_busy}, {31'd0, b});
         if (b) check("rs2_tag", {28'd0, rs2_tag}, {28'd0, t});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      rdy = 1; rollback = 0; issue = 0; reg_write = 0;
      issue_rd = 0; issue_rob_pos = 0; reg_rd = 0; reg_val = 0; commit_rob_pos = 0;
   endtask

   task automatic do_issue(input logic [4:0] rd, input logic [TAG_W-1:0] pos);
      idle(); issue = 1; issue_rd = rd; issue_rob_pos = pos;
      tick(); idle();
   endtask

   initial begin
      idle(); rst = 0; rs1 = 5; rs2 = 0;
      repeat (3) tick();
      rst = 1; chk_on = 1;
      #1;
      check("reset_val", rs1_val, 32'h0);
      check("reset_busy", {31'd0, rs1_busy}, 32'd0);
      check("reset_tag", {28'd0, rs1_tag}, 32'd0);

      do_issue(5, 3);
      rs1 = 5; #1;
      check("issue_busy", {31'd0, rs1_busy}, 32'd1);
      check("issue_tag", {28'd0, rs1_tag}, 32'd3);
      check("model_busy5", {31'd0, m_busy[5]}, 32'd1);

      reg_write = 1; reg_rd = 5; commit_rob_pos = 3; reg_val = 32'hDEADBEEF; #1;
`ifdef REG_FILE_BYPASS_EN
      check("bypass_busy", {31'd0, rs1_busy}, 32'd0);
      check("bypass_val", rs1_val, 32'hDEADBEEF);
`else
      check("nobypass_busy", {31'd0, rs1_busy}, 32'd1);
`endif
      tick(); idle(); #1;
      check("commit_busy", {31'd0, rs1_busy}, 32'd0);
      check("commit_val", rs1_val, 32'hDEADBEEF);

      do_issue(7, 1);
      do_issue(7, 2);
      reg_write = 1; reg_rd = 7; commit_rob_pos = 1; reg_val = 32'h11;
      tick(); idle(); rs1 = 7; #1;
      check("stale_val", rs1_val, 32'h11);
      check("stale_busy", {31'd0, rs1_busy}, 32'd1);
      check("stale_tag", {28'd0, rs1_tag}, 32'd2);

      reg_write = 1; reg_rd = 9; commit_rob_pos = 4; reg_val = 32'h55;
      issue = 1; issue_rd = 9; issue_rob_pos = 6;
      rs2 = 9; #1;
      check("collide_pre_busy", {31'd0, rs2_busy}, 32'd0);
      tick(); idle(); #1;
      check("collide_val", rs2_val, 32'h55);
      check("collide_busy", {31'd0, rs2_busy}, 32'd1);
      check("collide_tag", {28'd0, rs2_tag}, 32'd6);

      do_issue(1, 1);
      do_issue(2, 2);
      do_issue(3, 3);
      rollback = 1; reg_write = 1; reg_rd = 1; commit_rob_pos = 9; reg_val = 32'h100;
      issue = 1; issue_rd = 4; issue_rob_pos = 7;
      tick(); idle();
      for (int r = 1; r <= 4; r++) begin
         rs1 = 5'(r); #1;
         check("rollback_busy", {31'd0, rs1_busy}, 32'd0);
      end
      rs1 = 1; #1;
      check("rollback_val", rs1_val, 32'h100);
      check("rollback_tag4_model", {28'd0, m_tag[4]}, 32'd0);

      rdy = 0; issue = 1; issue_rd = 6; issue_rob_pos = 2;
      reg_write = 1; reg_rd = 6; reg_val = 32'hABCD; rollback = 1;
      tick(); idle(); rs1 = 6; #1;
      check("stall_busy", {31'd0, rs1_busy}, 32'd0);
      check("stall_val", rs1_val, 32'h0);

      reg_write = 1; reg_rd = 0; reg_val = 32'hFFFF; issue = 1; issue_rd = 0; issue_rob_pos = 5;
      tick(); idle(); rs1 = 0; #1;
      check("x0_val", rs1_val, 32'h0);
      check("x0_busy", {31'd0, rs1_busy}, 32'd0);

      for (int c = 0; c < 3000; c++) begin
         rst            = ($urandom_range(0, 99) != 0);
         rdy            = ($urandom_range(0, 9) != 0);
         rollback       = ($urandom_range(0, 19) == 0);
         issue          = ($urandom_range(0, 2) != 0);
         issue_rd       = 5'($urandom_range(0, 31));
         issue_rob_pos  = TAG_W'($urandom);
         reg_write      = ($urandom_range(0, 1) != 0);
         reg_rd         = 5'($urandom_range(0, 31));
         reg_val        = $urandom;
         commit_rob_pos = TAG_W'($urandom);
         if ($urandom_range(0, 1) != 0 && reg_rd != 0) commit_rob_pos = m_tag[reg_rd];
         rs1            = ($urandom_range(0, 3) == 0) ? reg_rd : 5'($urandom_range(0, 31));
         rs2            = 5'($urandom_range(0, 31));
         tick();
      end
      rst = 1; idle(); tick();
      chk_on = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected end by 2000000");
      $fatal(1);
   end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter: TAG_W, default 4, width of a reorder-buffer position tag.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-low (0 = reset), sampled on the rising clk edge.
REQ-004 rdy  input  1  global enable; 0 freezes all state.
REQ-005 rollback  input  1  pipeline flush from the reorder buffer.
REQ-006 issue  input  1  an instruction is being issued this cycle.
REQ-007 issue_rd  input  5  destination register of the issuing instruction.
REQ-008 issue_rob_pos  input  TAG_W  reorder-buffer slot allocated to the issuing instruction.
REQ-009 reg_write  input  1  commit write strobe from the reorder buffer.
REQ-010 reg_rd  input  5  commit destination register.
REQ-011 reg_val  input  32  commit value.
REQ-012 commit_rob_pos  input  TAG_W  reorder-buffer slot being committed.
REQ-013 rs1, rs2  input  5 each  source register indices from decode.
REQ-014 rs1_val, rs2_val  output  32 each  operand value, combinational.
REQ-015 rs1_busy, rs2_busy  output  1 each  operand awaits an in-flight producer, combinational.
REQ-016 rs1_tag, rs2_tag  output  TAG_W each  reorder-buffer slot of the pending producer; valid only when busy.

Function
REQ-017 Storage: 32 x 32-bit values, 32 busy bits and 32 TAG_W-bit tags.
REQ-018 x0: reads return value 0, busy 0 and tag 0; writes and issues to x0 are ignored.
REQ-019 Issue (issue=1, issue_rd!=0, rollback=0): at the edge, set busy[issue_rd]=1 and tag[issue_rd]=issue_rob_pos.
REQ-020 Commit (reg_write=1, reg_rd!=0): at the edge, write val[reg_rd]=reg_val unconditionally.
REQ-021 Commit also clears busy[reg_rd] at the edge, but only when tag[reg_rd]==commit_rob_pos; a tag mismatch leaves busy and tag unchanged.
REQ-022 Issue and commit to the same rd in one cycle: the value is written, busy stays 1, and the tag takes issue_rob_pos (issue wins).
REQ-023 Read ports show pre-edge state; the current cycle's issue never affects its own operand outputs.
REQ-024 Rollback=1: at the edge, clear all 32 busy bits and ignore issue that cycle.
REQ-025 Rollback=1: a commit in the same cycle still writes its value (covers jump-and-link-register link write); values otherwise retained.
REQ-026 rdy=0: no state changes, regardless of issue, reg_write or rollback.
REQ-027 Tag compare uses all TAG_W bits; there is no wrap-around ambiguity because the reorder buffer holds at most 2^TAG_W entries.

Reset
REQ-028 rst=0 at the edge: all values, busy bits and tags go to 0; reset overrides rdy, rollback, issue and commit.
REQ-029 Outputs are combinational from state, so after reset every rsN_val, rsN_busy and rsN_tag reads 0.

Configuration
REQ-030 Macro REG_FILE_BYPASS_EN, when defined, enables a commit-to-read bypass per read port.
REQ-031 The bypass applies when reg_write=1, rsN==reg_rd!=0, busy[rsN]=1 and tag[rsN]==commit_rob_pos.
REQ-032 When the bypass applies: rsN_val=reg_val, rsN_busy=0 and rsN_tag=0 in the same cycle.
REQ-033 Without REG_FILE_BYPASS_EN, read ports show stored state only, and the operand becomes ready one cycle after the commit.

Verification
REQ-034 Reset: hold rst=0 then release; read x5 -> val 0, busy 0, tag 0.
REQ-035 Issue then commit:
- issue rd=5, rob_pos=3; next cycle read x5 -> busy 1, tag 3.
- Commit rd=5, pos=3, val=0xDEADBEEF -> next cycle busy 0, val 0xDEADBEEF.
- With REG_FILE_BYPASS_EN, the commit cycle itself reads busy 0, val 0xDEADBEEF.
REQ-036 Stale tag: issue rd=7 at pos 1, then rd=7 at pos 2; commit pos 1 with val 0x11 -> val 0x11, busy 1, tag 2.
REQ-037 Same-cycle collision: commit rd=9 pos 4 with val 0x55 while issuing rd=9 pos 6 -> val 0x55, busy 1, tag 6.
REQ-038 Rollback with commit:
- Mark x1, x2 and x3 busy.
- Assert rollback together with commit rd=1 val 0x100 and issue rd=4 -> x1..x4 busy 0, x1=0x100, tag of x4 unchanged.
REQ-039 Stall and x0:
- rdy=0 with issue rd=6 -> x6 unchanged.
- Commit rd=0 val 0xFFFF -> x0 reads 0, not busy.
